// File: rtl/dn_load_sequencer.sv
// dn_load_sequencer
//
// Receives hps_io download bytes and buffers each byte, with its decoded target and address,
// in a small show-ahead FIFO. The FIFO head is offered to a shared RAM write port over a
// req/gnt handshake. The block holds the core in reset while a download is running. It then
// drains the FIFO and keeps the reset asserted for HOLD_CYCLES more cycles before it releases
// the core. Power-on goes through the same hold interval.
//
// Ports:
//   clk_sys, reset_n            clock, asynchronous active-low reset
//   dn_download/index/addr/data ioctl download interface; dn_wr is a one-cycle write strobe
//   core_reset                  registered active-high reset to the core
//   wr_req/wr_gnt               RAM port handshake; the head pops on wr_req & wr_gnt
//   wr_target/wr_addr/wr_data   head entry (one-hot target); all zero while wr_req=0
//   busy, done, overflow        status: not idle, end-of-hold pulse, sticky FIFO overflow
//   checksum                    16-bit sum of popped bytes (only with DN_LOAD_CHECKSUM_EN)
//
// Optional feature: define DN_LOAD_CHECKSUM_EN to add the checksum output.

module dn_load_sequencer #(
  parameter int unsigned ADDR_W      = 17,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned HOLD_CYCLES = 256,
  parameter int unsigned NUM_TARGETS = 2
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   dn_download,
  input  logic [7:0]             dn_index,
  input  logic [ADDR_W-1:0]      dn_addr,
  input  logic [7:0]             dn_data,
  input  logic                   dn_wr,
  output logic                   core_reset,
  output logic                   wr_req,
  input  logic                   wr_gnt,
  output logic [NUM_TARGETS-1:0] wr_target,
  output logic [ADDR_W-1:0]      wr_addr,
  output logic [7:0]             wr_data,
  output logic                   busy,
  output logic                   done,
`ifdef DN_LOAD_CHECKSUM_EN
  output logic [15:0]            checksum,
`endif
  output logic                   overflow
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int unsigned EntW = NUM_TARGETS + ADDR_W + 8;
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD_CYCLES - 1);
  localparam logic [PtrW:0]   PtrOne  = (PtrW + 1)'(1);
  localparam logic [7:0]      NumTgt8 = 8'(NUM_TARGETS);

  typedef enum logic [1:0] {StIdle, StLoad, StDrain, StHold} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            init_q;
  logic            core_reset_q, core_reset_d;
  logic            done_q, done_d;
  logic            overflow_q, overflow_d;
  logic [PtrW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EntW-1:0] mem_q [FIFO_DEPTH];

  logic                   start, load_entry, push_en;
  logic                   empty, full, do_push, do_pop;
  logic [NUM_TARGETS-1:0] push_tgt;
  logic [EntW-1:0]        head_ent;

  assign start = dn_download && (dn_index < NumTgt8);

  // Pointers carry one extra bit so full and empty can be told apart when the indices match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign do_pop   = !empty && wr_gnt;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push  = push_en && dn_wr && (!full || do_pop);
  assign head_ent = mem_q[rd_ptr_q[PtrW-1:0]];

  always_comb begin
    push_tgt = '0;
    for (int unsigned i = 0; i < NUM_TARGETS; i++) begin
      push_tgt[i] = (dn_index == 8'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_d     = 1'b0;
    load_entry = 1'b0;
    push_en    = 1'b0;
    unique case (state_q)
      StIdle: begin
        // The first cycle after reset goes through the normal hold interval.
        if (init_q) begin
          state_d = StHold;
          cnt_d   = HoldMax;
        end else if (start) begin
          state_d    = StLoad;
          load_entry = 1'b1;
          push_en    = 1'b1;
        end
      end
      StLoad: begin
        push_en = 1'b1;
        if (!dn_download) state_d = StDrain;
      end
      StDrain: begin
        if (empty) begin
          state_d = StHold;
          cnt_d   = HoldMax;
        end
      end
      StHold: begin
        if (start) begin
          state_d    = StLoad;
          load_entry = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    core_reset_d = (state_d != StIdle);
    overflow_d   = load_entry ? 1'b0 : (overflow_q | (push_en && dn_wr && full && !do_pop));
    wr_ptr_d     = do_push ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d     = do_pop  ? rd_ptr_q + PtrOne : rd_ptr_q;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      init_q       <= 1'b1;
      core_reset_q <= 1'b1;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      init_q       <= 1'b0;
      core_reset_q <= core_reset_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset; entries are only read while the FIFO is non-empty.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem_q[wr_ptr_q[PtrW-1:0]] <= {push_tgt, dn_addr, dn_data};
  end

`ifdef DN_LOAD_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (load_entry) begin
      sum_d = '0;
    end else if (do_pop) begin
      sum_d = sum_q + {8'h00, head_ent[7:0]};
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) sum_q <= '0;
    else          sum_q <= sum_d;
  end

  assign checksum = sum_q;
`endif

  assign core_reset = core_reset_q;
  assign wr_req     = !empty;
  assign wr_target  = wr_req ? head_ent[EntW-1 -: NUM_TARGETS] : '0;
  assign wr_addr    = wr_req ? head_ent[ADDR_W+7:8] : '0;
  assign wr_data    = wr_req ? head_ent[7:0] : '0;
  assign busy       = (state_q != StIdle) || init_q;
  assign done       = done_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_dn_load_sequencer.sv
// Scoreboard bench for dn_load_sequencer. Stimulus is driven 1 time unit after each rising
// edge. A reference model updates on the rising edge: it tracks FIFO occupancy, drops,
// overflow and the expected release edge. A monitor on the falling edge compares every pop
// against the expected queue.

module tb_dn_load_sequencer;

  localparam int ADDR_W = 17;
  localparam int DEPTH  = 4;
  localparam int HOLD   = 256;
  localparam int NT     = 2;

  typedef struct {
    logic [NT-1:0]     tgt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ent_t;

  logic              clk_sys     = 1'b0;
  logic              reset_n     = 1'b0;
  logic              dn_download = 1'b0;
  logic [7:0]        dn_index    = '0;
  logic [ADDR_W-1:0] dn_addr     = '0;
  logic [7:0]        dn_data     = '0;
  logic              dn_wr       = 1'b0;
  logic              wr_gnt      = 1'b0;
  logic              core_reset, wr_req, busy, done, overflow;
  logic [NT-1:0]     wr_target;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
`ifdef DN_LOAD_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state.
  ent_t exp_q[$];
  ent_t m_e;
  int   cyc            = 0;
  int   m_occ          = 0;
  int   m_release_edge = 0;
  int   m_sum          = 0;
  bit   m_ovf          = 1'b0;
  bit   m_pop          = 1'b0;
  bit   m_start        = 1'b0;
  bit   m_accept       = 1'b0;
  bit   m_draining     = 1'b0;

  dn_load_sequencer #(
    .ADDR_W     (ADDR_W),
    .FIFO_DEPTH (DEPTH),
    .HOLD_CYCLES(HOLD),
    .NUM_TARGETS(NT)
  ) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .dn_download(dn_download),
    .dn_index   (dn_index),
    .dn_addr    (dn_addr),
    .dn_data    (dn_data),
    .dn_wr      (dn_wr),
    .core_reset (core_reset),
    .wr_req     (wr_req),
    .wr_gnt     (wr_gnt),
    .wr_target  (wr_target),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
`ifdef DN_LOAD_CHECKSUM_EN
    .checksum   (checksum),
`endif
    .overflow   (overflow)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired, got no event expected one (edge %0d)", name, cyc);
  endtask

  // Reference model. It applies at each edge the rules for FIFO push, pop, drop and drain.
  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      cyc   = 0;
      m_occ = 0;
      m_ovf = 1'b0;
      exp_q.delete();
    end else begin
      cyc++;
      m_pop = (m_occ > 0) && (wr_gnt === 1'b1);
      if (m_start) begin
        m_ovf   = 1'b0;
        m_sum   = 0;
        m_start = 1'b0;
      end
      if (m_accept && dn_wr === 1'b1) begin
        if (m_occ < DEPTH || m_pop) begin
          m_e.tgt  = NT'(1) << dn_index;
          m_e.addr = dn_addr;
          m_e.data = dn_data;
          exp_q.push_back(m_e);
          m_occ++;
        end else begin
          m_ovf = 1'b1;
        end
      end
      if (m_pop) m_occ--;
      // The FIFO has drained: one cycle to enter hold, then HOLD hold cycles.
      if (m_draining && m_occ == 0) begin
        m_release_edge = cyc + HOLD + 1;
        m_draining     = 1'b0;
      end
    end
  end

  // Monitor: checks the request against model occupancy and pops the scoreboard on a grant.
  always @(negedge clk_sys) begin
    ent_t e;
    if (reset_n) begin
      chk("wr_req_vs_model", {31'd0, wr_req}, {31'd0, (m_occ > 0)});
      if (wr_req !== 1'b1) chk("idle_target_zero", {30'd0, wr_target}, 32'd0);
      if (wr_req === 1'b1 && wr_gnt === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("pop_without_entry", {30'd0, wr_target}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (wr_target !== e.tgt || wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL pop_entry: got tgt=%0h addr=%0h data=%0h expected tgt=%0h addr=%0h data=%0h",
                     wr_target, wr_addr, wr_data, e.tgt, e.addr, e.data);
          end
          m_sum += int'(e.data);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic start_dl(input logic [7:0] idx, input logic wr, input logic [ADDR_W-1:0] a,
                          input logic [7:0] d, input logic g);
    dn_download    = 1'b1;
    dn_index       = idx;
    dn_wr          = wr;
    dn_addr        = a;
    dn_data        = d;
    wr_gnt         = g;
    m_start        = 1'b1;
    m_accept       = 1'b1;
    m_release_edge = 0;
    step();
  endtask

  task automatic push_cyc(input logic wr, input logic [ADDR_W-1:0] a, input logic [7:0] d,
                          input logic g);
    dn_wr   = wr;
    dn_addr = a;
    dn_data = d;
    wr_gnt  = g;
    step();
  endtask

  task automatic end_dl();
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    m_accept    = 1'b0;
    m_draining  = 1'b1;
    step();
  endtask

  // Waits for the release edge the model predicted and checks the edge exactly.
  task automatic wait_release();
    int guard = 0;
    bit bad   = 1'b0;
    while ((m_release_edge == 0 || cyc < m_release_edge - 1) && guard < 2000) begin
      if (core_reset !== 1'b1 || done !== 1'b0 || busy !== 1'b1) bad = 1'b1;
      wr_gnt = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    chk("hold_window", {31'd0, bad}, 32'd0);
    if (m_release_edge == 0 || cyc != m_release_edge - 1) begin
      fail("release_timeout");
      return;
    end
    chk("hold_last", {30'd0, core_reset, done}, 32'b10);
    step();
    chk("release", {29'd0, core_reset, done, busy}, 32'b010);
    chk("overflow_at_done", {31'd0, overflow}, {31'd0, m_ovf});
`ifdef DN_LOAD_CHECKSUM_EN
    chk("checksum_at_done", {16'd0, checksum}, {16'd0, 16'(m_sum)});
`endif
    step();
    chk("done_pulse_width", {31'd0, done}, 32'd0);
    chk("queue_drained", exp_q.size(), 32'd0);
    m_release_edge = 0;
  endtask

  initial begin
    int guard;
    int n;

    // Reset values while reset_n is low.
    #12;
    chk("reset_flags", {27'd0, core_reset, wr_req, busy, done, overflow}, 32'b10100);
    chk("reset_bus", {5'd0, wr_target, wr_addr, wr_data}, 32'd0);
    @(posedge clk_sys);
    #3;
    reset_n        = 1'b1;
    m_release_edge = HOLD + 1;
    wait_release();

    // Index 1, eight bytes, grant always given; the first byte arrives on the start cycle.
    start_dl(8'd1, 1'b1, 17'd0, 8'h10, 1'b1);
    for (int i = 1; i < 8; i++) push_cyc(1'b1, ADDR_W'(i), 8'(8'h10 + i), 1'b1);
    end_dl();
    wait_release();

    // Unsupported index: the download is ignored.
    dn_download = 1'b1;
    dn_index    = 8'd5;
    for (int i = 0; i < 6; i++) begin
      dn_wr   = 1'(i % 2);
      dn_addr = ADDR_W'(i);
      step();
      chk("ignored_index", {29'd0, core_reset, wr_req, busy}, 32'd0);
    end
    dn_download = 1'b0;
    dn_wr       = 1'b0;
    step();

    // Six back-to-back writes with no grant: the last two are dropped.
    start_dl(8'd0, 1'b1, 17'h1abc0, 8'h40, 1'b0);
    for (int i = 1; i < 6; i++) push_cyc(1'b1, ADDR_W'(17'h1abc0 + i), 8'(8'h40 + i), 1'b0);
    push_cyc(1'b0, '0, '0, 1'b0);
    chk("overflow_set", {31'd0, overflow}, 32'd1);
    chk("req_held", {31'd0, wr_req}, 32'd1);
    chk("head_addr", {15'd0, wr_addr}, 32'h1abc0);
    for (int i = 0; i < 3; i++) push_cyc(1'b0, '0, '0, 1'b0);
    chk("head_addr_stable", {15'd0, wr_addr}, 32'h1abc0);
    end_dl();
    wait_release();

    // Full FIFO with push and pop together: accepted, no overflow, still full afterwards.
    start_dl(8'd0, 1'b1, 17'h00100, 8'h01, 1'b0);
    for (int i = 1; i < 4; i++) push_cyc(1'b1, ADDR_W'(17'h00100 + i), 8'(i + 1), 1'b0);
    push_cyc(1'b1, 17'h00104, 8'h05, 1'b1);
    push_cyc(1'b0, '0, '0, 1'b0);
    chk("full_push_pop_no_ovf", {31'd0, overflow}, 32'd0);
    push_cyc(1'b1, 17'h00105, 8'h06, 1'b0);
    push_cyc(1'b0, '0, '0, 1'b0);
    chk("still_full_drop", {31'd0, overflow}, 32'd1);
    end_dl();

    // Re-enter LOAD from HOLD when the counter reads 100.
    guard = 0;
    while ((m_release_edge == 0 || cyc < m_release_edge - 101) && guard < 2000) begin
      wr_gnt = 1'($urandom_range(0, 1));
      step();
      guard++;
    end
    if (m_release_edge == 0) begin
      fail("drain_timeout_hold_restart");
    end else begin
      chk("hold_at_100", {29'd0, core_reset, busy, done}, 32'b110);
      start_dl(8'd0, 1'b0, '0, '0, 1'b0);
      chk("restart_ovf_cleared", {31'd0, overflow}, 32'd0);
      chk("restart_no_done", {30'd0, core_reset, done}, 32'b10);
      push_cyc(1'b1, 17'h00200, 8'hff, 1'b1);
      push_cyc(1'b1, 17'h00201, 8'hff, 1'b1);
      push_cyc(1'b1, 17'h00202, 8'h02, 1'b1);
      end_dl();
      wait_release();
`ifdef DN_LOAD_CHECKSUM_EN
      chk("checksum_ff_ff_02", {16'd0, checksum}, 32'h0200);
`endif
    end

    // Randomized downloads with random gaps, grants and mid-download index changes.
    for (int d = 0; d < 5; d++) begin
      n = $urandom_range(1, 12);
      start_dl(8'($urandom_range(0, NT - 1)), 1'($urandom_range(0, 1)), ADDR_W'($urandom),
               8'($urandom), 1'($urandom_range(0, 1)));
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 4) == 0) dn_index = 8'($urandom_range(0, NT - 1));
        push_cyc(1'($urandom_range(0, 1)), ADDR_W'($urandom), 8'($urandom),
                 1'($urandom_range(0, 1)));
      end
      end_dl();
      wait_release();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
